// File: rtl/sys_arr_collector.sv
// Deskews bottom-row column sums into aligned vectors and queues them in a FIFO for downstream.
// Latency row_width cycles to out_valid; out_ready stalls the head, a full FIFO drops the vector and flags overflow.
module sys_arr_collector #(
    parameter int row_width  = 2,
    parameter int fifo_depth = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic [16*row_width-1:0] maccin,
    input  logic [row_width-1:0]    activein,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [16*row_width-1:0] out_data,
    output logic                    overflow,
    output logic                    skew_err,
    output logic [15:0]             vec_count
);

    localparam int dw = 16*row_width;
    localparam int aw = $clog2(fifo_depth);

    logic [dw-1:0]        al_sum;
    logic [row_width-1:0] al_act;

    // Column i enters row_width-1-i cycles before the rightmost column of its wavefront.
    for (genvar i = 0; i < row_width; i++) begin : g_col
        localparam int depth = row_width - 1 - i;
        if (depth == 0) begin : g_direct
            assign al_sum[16*i +: 16] = maccin[16*i +: 16];
            assign al_act[i]          = activein[i];
        end else begin : g_dly
            logic [16:0] stg [depth];
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < depth; k++) stg[k] <= '0;
                end else if (clear) begin
                    for (int k = 0; k < depth; k++) stg[k] <= '0;
                end else begin
                    stg[0] <= {activein[i], maccin[16*i +: 16]};
                    for (int k = 1; k < depth; k++) stg[k] <= stg[k-1];
                end
            end
            assign {al_act[i], al_sum[16*i +: 16]} = stg[depth-1];
        end
    end

    logic          all_on;
    logic          mixed;
    logic [aw:0]   wr_ptr;
    logic [aw:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic [dw-1:0] mem [fifo_depth];

    assign all_on = &al_act;
    assign mixed  = (|al_act) & ~all_on;
    assign full   = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
    assign empty  = (wr_ptr == rd_ptr);
    assign pop    = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push   = all_on & (~full | pop);

    assign out_valid = ~empty;
    assign out_data  = out_valid ? mem[rd_ptr[aw-1:0]] : '0;

    always_ff @(posedge clock) begin
        if (push && !clear) mem[wr_ptr[aw-1:0]] <= al_sum;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            skew_err  <= 1'b0;
            vec_count <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            skew_err  <= 1'b0;
            vec_count <= '0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                vec_count <= vec_count + 16'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (all_on && !push) overflow <= 1'b1;
            if (mixed) skew_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sys_arr_collector.sv
// Bench for sys_arr_collector (row_width=2, fifo_depth=4): table vectors, scoreboard, corner sequences.
module tb_sys_arr_collector;

    logic        clock;
    logic        reset_n;
    logic        clear;
    logic [31:0] maccin;
    logic [1:0]  activein;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        overflow;
    logic        skew_err;
    logic [15:0] vec_count;

    sys_arr_collector #(.row_width(2), .fifo_depth(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clear),
        .maccin    (maccin),
        .activein  (activein),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overflow  (overflow),
        .skew_err  (skew_err),
        .vec_count (vec_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: column 0 delayed one cycle, FIFO as a queue.
    logic [31:0] exp_q[$];
    logic        m_prev_act;
    logic [15:0] m_prev_sum;
    logic [15:0] m_cnt;
    logic        m_ovf;
    logic        m_skew;

    typedef struct {
        string       name;
        logic [1:0]  act0;
        logic [31:0] sum0;
        logic [1:0]  act1;
        logic [31:0] sum1;
        logic        exp_vld;
        logic        exp_skew;
        logic [31:0] exp_dat;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_prev_act = 1'b0;
        m_prev_sum = '0;
        m_cnt      = '0;
        m_ovf      = 1'b0;
        m_skew     = 1'b0;
    endtask

    task automatic do_cycle(input logic [1:0] act, input logic [31:0] sum, input logic rdy, input logic clr);
        logic pop;
        logic full;
        activein  = act;
        maccin    = sum;
        out_ready = rdy;
        clear     = clr;
        chk("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
        if (clr) begin
            model_reset();
        end else begin
            pop  = (exp_q.size() != 0) && rdy;
            full = (exp_q.size() == 4);
            if (pop) void'(exp_q.pop_front());
            if (m_prev_act && act[1]) begin
                if (!full || pop) begin
                    exp_q.push_back({sum[31:16], m_prev_sum});
                    m_cnt++;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_prev_act != act[1]) begin
                m_skew = 1'b1;
            end
            m_prev_act = act[0];
            m_prev_sum = sum[15:0];
        end
        @(posedge clock);
        #1;
        chk("overflow", overflow, m_ovf);
        chk("skew_err", skew_err, m_skew);
        chk("vec_count", vec_count, m_cnt);
    endtask

    // n back-to-back wavefronts: col0 = base+j, col1 = base+0x1000+j.
    task automatic wf_burst(input int n, input logic rdy_last, input logic [15:0] base);
        logic [1:0]  act;
        logic [31:0] sum;
        for (int c = 0; c <= n; c++) begin
            act[0]      = (c < n);
            act[1]      = (c >= 1);
            sum[15:0]   = (c < n) ? base + 16'(c) : 16'h0;
            sum[31:16]  = (c >= 1) ? base + 16'h1000 + 16'(c - 1) : 16'h0;
            do_cycle(act, sum, rdy_last && (c == n), 1'b0);
        end
    endtask

    initial begin
        tbl[0] = '{"basic",    2'b01, 32'h0000_0005, 2'b10, 32'hFFFE_0000, 1'b1, 1'b0, 32'hFFFE_0005, 16'd1};
        tbl[1] = '{"skew_c0",  2'b01, 32'h0000_0033, 2'b00, 32'h0000_0000, 1'b0, 1'b1, 32'h0,         16'd0};
        tbl[2] = '{"skew_c1",  2'b00, 32'h0000_0000, 2'b10, 32'h4444_0000, 1'b0, 1'b1, 32'h0,         16'd0};
        tbl[3] = '{"idle",     2'b00, 32'h0000_1234, 2'b00, 32'h5678_0000, 1'b0, 1'b0, 32'h0,         16'd0};
        tbl[4] = '{"no_sext",  2'b01, 32'h0000_8000, 2'b10, 32'h7FFF_0000, 1'b1, 1'b0, 32'h7FFF_8000, 16'd1};
        tbl[5] = '{"extremes", 2'b01, 32'h0000_FFFF, 2'b10, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_FFFF, 16'd1};

        reset_n   = 1'b0;
        clear     = 1'b0;
        maccin    = '0;
        activein  = '0;
        out_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_skew_err", skew_err, 1'b0);
        chk("rst_vec_count", vec_count, 16'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        for (int t = 0; t < 6; t++) begin
            do_cycle(2'b00, 32'h0, 1'b0, 1'b1);
            do_cycle(tbl[t].act0, tbl[t].sum0, 1'b0, 1'b0);
            do_cycle(tbl[t].act1, tbl[t].sum1, 1'b0, 1'b0);
            chk({tbl[t].name, "_valid"}, out_valid, tbl[t].exp_vld);
            chk({tbl[t].name, "_skew"}, skew_err, tbl[t].exp_skew);
            chk({tbl[t].name, "_count"}, vec_count, tbl[t].exp_cnt);
            if (tbl[t].exp_vld) chk({tbl[t].name, "_data"}, out_data, tbl[t].exp_dat);
        end

        // Five wavefronts into a stalled 4-deep FIFO, then drain in order.
        do_cycle(2'b00, 32'h0, 1'b0, 1'b1);
        wf_burst(5, 1'b0, 16'h1000);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_count", vec_count, 16'd4);
        chk("ovf_head", out_data, 32'h2000_1000);
        for (int k = 0; k < 4; k++) do_cycle(2'b00, 32'h0, 1'b1, 1'b0);
        chk("ovf_drained", out_valid, 1'b0);

        // Full FIFO, pop and aligned push on the same edge.
        do_cycle(2'b00, 32'h0, 1'b0, 1'b1);
        wf_burst(5, 1'b1, 16'h0100);
        chk("fullpp_ovf", overflow, 1'b0);
        chk("fullpp_count", vec_count, 16'd5);
        chk("fullpp_head", out_data, 32'h1101_0101);
        chk("fullpp_occ", exp_q.size(), 32'd4);
        for (int k = 0; k < 4; k++) do_cycle(2'b00, 32'h0, 1'b1, 1'b0);
        chk("fullpp_drained", out_valid, 1'b0);

        // Async reset between edges with a partial wavefront in flight.
        do_cycle(2'b00, 32'h0, 1'b0, 1'b1);
        do_cycle(2'b01, 32'h0000_0077, 1'b0, 1'b0);
        do_cycle(2'b10, 32'h0066_0000, 1'b0, 1'b0);
        do_cycle(2'b01, 32'h0000_0001, 1'b0, 1'b0);
        do_cycle(2'b00, 32'h0, 1'b0, 1'b0);
        do_cycle(2'b01, 32'h0000_00AA, 1'b0, 1'b0);
        chk("pre_rst_valid", out_valid, 1'b1);
        activein = 2'b10;
        maccin   = 32'h00BB_0000;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_valid", out_valid, 1'b0);
        chk("async_data", out_data, 32'h0);
        chk("async_ovf", overflow, 1'b0);
        chk("async_skew", skew_err, 1'b0);
        chk("async_count", vec_count, 16'h0);
        model_reset();
        activein = 2'b00;
        maccin   = '0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        do_cycle(2'b01, 32'h0000_0011, 1'b0, 1'b0);
        do_cycle(2'b10, 32'h0022_0000, 1'b0, 1'b0);
        chk("post_rst_count", vec_count, 16'd1);
        chk("post_rst_data", out_data, 32'h0022_0011);

        // clear with 3 queued, a push aligning that cycle and sticky skew set.
        do_cycle(2'b00, 32'h0, 1'b0, 1'b1);
        do_cycle(2'b01, 32'h0000_0009, 1'b0, 1'b0);
        do_cycle(2'b00, 32'h0, 1'b0, 1'b0);
        do_cycle(2'b01, 32'h0000_0A00, 1'b0, 1'b0);
        do_cycle(2'b11, 32'h0B00_0A01, 1'b0, 1'b0);
        do_cycle(2'b11, 32'h0B01_0A02, 1'b0, 1'b0);
        do_cycle(2'b11, 32'h0B02_0A03, 1'b0, 1'b0);
        chk("preclr_count", vec_count, 16'd3);
        do_cycle(2'b10, 32'h0B03_0000, 1'b0, 1'b1);
        chk("clr_valid", out_valid, 1'b0);
        chk("clr_count", vec_count, 16'd0);
        chk("clr_skew", skew_err, 1'b0);
        chk("clr_ovf", overflow, 1'b0);
        do_cycle(2'b00, 32'h0, 1'b1, 1'b0);
        chk("clr_after_valid", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
